mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter onto a single-port memory.
// Alternating tie-break, bounded wait with sticky timeout error, CPU stall.
module mem_arbiter #(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  output logic        dm_gnt_o,
  output logic        dm_rvalid_o,
  output logic [31:0] dm_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        cpu_stall_o,
  output logic        err_o
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   wait_q, wait_d;
  logic            last_dm_q, last_dm_d;
  logic            if_gnt_d, dm_gnt_d, if_rvalid_d, dm_rvalid_d;
  logic [DW-1:0]   if_rdata_d, dm_rdata_d;
  logic            mem_req_d, mem_we_d, err_d;
  logic [DW-1:0]   mem_addr_d, mem_wdata_d;
  logic            cool, pick_dm, pick_if, done;
  logic [DW-1:0]   resp;

  // The cycle carrying an rvalid pulse is a forced idle cycle: no acceptance.
  assign cool    = if_rvalid_o | dm_rvalid_o;
  assign pick_dm = dm_req_i & (~if_req_i | ~last_dm_q);
  assign pick_if = if_req_i & ~pick_dm;
  assign done    = mem_ack_i | (wait_q == CW'(TIMEOUT - 1));
  assign resp    = mem_we_o ? '0 : (mem_ack_i ? mem_rdata_i : ERR_DATA);

  assign cpu_stall_o = (state_q != IDLE) | if_req_i | dm_req_i;

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    last_dm_d   = last_dm_q;
    if_gnt_d    = 1'b0;
    dm_gnt_d    = 1'b0;
    if_rvalid_d = 1'b0;
    dm_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_o;
    dm_rdata_d  = dm_rdata_o;
    mem_req_d   = mem_req_o;
    mem_we_d    = mem_we_o;
    mem_addr_d  = mem_addr_o;
    mem_wdata_d = mem_wdata_o;
    err_d       = err_o;
    case (state_q)
      IDLE: begin
        if (!cool && pick_dm) begin
          state_d     = BUSY_DM;
          dm_gnt_d    = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we_i;
          mem_addr_d  = dm_addr_i;
          mem_wdata_d = dm_wdata_i;
          wait_d      = '0;
          last_dm_d   = 1'b1;
        end else if (!cool && pick_if) begin
          state_d     = BUSY_IF;
          if_gnt_d    = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr_i;
          mem_wdata_d = '0;
          wait_d      = '0;
          last_dm_d   = 1'b0;
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (done) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          if (!mem_ack_i) err_d = 1'b1;
          if (state_q == BUSY_DM) begin
            dm_rvalid_d = 1'b1;
            dm_rdata_d  = resp;
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = resp;
          end
        end else begin
          wait_d = wait_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wait_q      <= '0;
      last_dm_q   <= 1'b0;
      if_gnt_o    <= 1'b0;
      dm_gnt_o    <= 1'b0;
      if_rvalid_o <= 1'b0;
      dm_rvalid_o <= 1'b0;
      if_rdata_o  <= '0;
      dm_rdata_o  <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      err_o       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      last_dm_q   <= last_dm_d;
      if_gnt_o    <= if_gnt_d;
      dm_gnt_o    <= dm_gnt_d;
      if_rvalid_o <= if_rvalid_d;
      dm_rvalid_o <= dm_rvalid_d;
      if_rdata_o  <= if_rdata_d;
      dm_rdata_o  <= dm_rdata_d;
      mem_req_o   <= mem_req_d;
      mem_we_o    <= mem_we_d;
      mem_addr_o  <= mem_addr_d;
      mem_wdata_o <= mem_wdata_d;
      err_o       <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then random traffic, all outputs
// compared every cycle against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int unsigned TIMEOUT  = 16;
  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, dm_req, dm_we, mem_ack;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid;
  logic [31:0] if_rdata, dm_rdata;
  logic        mem_req, mem_we, cpu_stall, err;
  logic [31:0] mem_addr, mem_wdata;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: owner 0=none 1=IF 2=DM
  int          owner, waited;
  bit          last_dm, cool;
  logic        e_if_gnt, e_dm_gnt, e_if_rv, e_dm_rv, e_mreq, e_mwe, e_err;
  logic [31:0] e_if_rd, e_dm_rd, e_maddr, e_mwdata;

  mem_arbiter #(.TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)) dut (
    .clk_i(clk), .rst_n(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr),
    .if_gnt_o(if_gnt), .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
    .dm_gnt_o(dm_gnt), .dm_rvalid_o(dm_rvalid), .dm_rdata_o(dm_rdata),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata),
    .cpu_stall_o(cpu_stall), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    else
      n_pass++;
  endtask

  task automatic model_reset();
    owner = 0; waited = 0; last_dm = 1'b0; cool = 1'b0;
    e_if_gnt = 0; e_dm_gnt = 0; e_if_rv = 0; e_dm_rv = 0;
    e_mreq = 0; e_mwe = 0; e_err = 0;
    e_if_rd = '0; e_dm_rd = '0; e_maddr = '0; e_mwdata = '0;
  endtask

  // One rising edge worth of behaviour, from the inputs present at that edge.
  task automatic model_edge();
    logic [31:0] v;
    bit take_dm;
    e_if_gnt = 0; e_dm_gnt = 0; e_if_rv = 0; e_dm_rv = 0;
    if (owner == 0) begin
      if (!cool && (if_req || dm_req)) begin
        take_dm = dm_req && (!if_req || !last_dm);
        owner   = take_dm ? 2 : 1;
        last_dm = take_dm;
        waited  = 0;
        e_mreq  = 1;
        if (take_dm) begin
          e_dm_gnt = 1; e_mwe = dm_we; e_maddr = dm_addr; e_mwdata = dm_wdata;
        end else begin
          e_if_gnt = 1; e_mwe = 0; e_maddr = if_addr; e_mwdata = '0;
        end
      end
    end else if (mem_ack || waited == int'(TIMEOUT) - 1) begin
      if (!mem_ack) e_err = 1;
      v = e_mwe ? 32'h0 : (mem_ack ? mem_rdata : ERR_DATA);
      e_mreq = 0;
      if (owner == 1) begin e_if_rv = 1; e_if_rd = v; end
      else            begin e_dm_rv = 1; e_dm_rd = v; end
      owner = 0;
    end else begin
      waited++;
    end
    cool = e_if_rv || e_dm_rv;
  endtask

  task automatic compare_all();
    check("if_gnt", if_gnt, e_if_gnt);
    check("dm_gnt", dm_gnt, e_dm_gnt);
    check("if_rvalid", if_rvalid, e_if_rv);
    check("dm_rvalid", dm_rvalid, e_dm_rv);
    check("if_rdata", if_rdata, e_if_rd);
    check("dm_rdata", dm_rdata, e_dm_rd);
    check("mem_req", mem_req, e_mreq);
    check("err", err, e_err);
    check("cpu_stall", cpu_stall, (owner != 0) || if_req || dm_req);
    if (e_mreq) begin
      check("mem_we", mem_we, e_mwe);
      check("mem_addr", mem_addr, e_maddr);
      check("mem_wdata", mem_wdata, e_mwdata);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  // Asserts reset between edges, checks the asynchronous clear, releases at a falling edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_we", mem_we, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int ack_pct;
    rst_n = 1'b0;
    if_req = 0; dm_req = 0; dm_we = 0; mem_ack = 0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
    model_reset();
    #2;
    do_reset();

    // Single fetch with ack in cycle 3
    if_req = 1; if_addr = 32'h40;
    step();
    check("fetch_gnt", if_gnt, 1);
    check("fetch_mreq", mem_req, 1);
    check("fetch_addr", mem_addr, 32'h40);
    if_req = 0;
    step(); step();
    check("fetch_addr_held", mem_addr, 32'h40);
    mem_ack = 1; mem_rdata = 32'h1234_5678;
    step();
    check("fetch_rvalid", if_rvalid, 1);
    check("fetch_rdata", if_rdata, 32'h1234_5678);
    mem_ack = 0;
    step();
    check("stall_after", cpu_stall, 0);

    // Tie right after reset: DM first, then IF
    do_reset();
    if_req = 1; dm_req = 1; if_addr = 32'h200; dm_addr = 32'h300; dm_we = 0;
    step();
    check("tie1_dm_gnt", dm_gnt, 1);
    check("tie1_if_gnt", if_gnt, 0);
    mem_ack = 1; mem_rdata = 32'h0BAD_F00D;
    step();
    mem_ack = 0;
    step();
    step();
    check("tie2_if_gnt", if_gnt, 1);
    check("tie2_dm_gnt", dm_gnt, 0);
    if_req = 0; dm_req = 0;
    mem_ack = 1;
    step();
    mem_ack = 0;
    step(); step();

    // Data write
    dm_req = 1; dm_we = 1; dm_addr = 32'h100; dm_wdata = 32'hA5A5_A5A5;
    step();
    check("wr_we", mem_we, 1);
    check("wr_addr", mem_addr, 32'h100);
    check("wr_wdata", mem_wdata, 32'hA5A5_A5A5);
    dm_req = 0; dm_we = 0;
    mem_ack = 1; mem_rdata = 32'hFFFF_0000;
    step();
    check("wr_rvalid", dm_rvalid, 1);
    check("wr_rdata", dm_rdata, 32'h0);
    mem_ack = 0;
    step(); step();

    // Ack on the last allowed cycle completes normally
    if_req = 1; if_addr = 32'h80;
    step();
    if_req = 0;
    for (int i = 0; i < int'(TIMEOUT) - 1; i++) step();
    mem_ack = 1; mem_rdata = 32'hCAFE_F00D;
    step();
    check("late_ack_rvalid", if_rvalid, 1);
    check("late_ack_rdata", if_rdata, 32'hCAFE_F00D);
    check("late_ack_err", err, 0);
    mem_ack = 0;
    step(); step();

    // Timeout abort
    if_req = 1; if_addr = 32'h84;
    step();
    if_req = 0;
    for (int i = 0; i < int'(TIMEOUT) - 1; i++) step();
    check("to_not_yet", if_rvalid, 0);
    step();
    check("to_rvalid", if_rvalid, 1);
    check("to_rdata", if_rdata, ERR_DATA);
    check("to_err", err, 1);
    step(); step(); step();
    check("to_err_sticky", err, 1);

    // Reset in the middle of a data read
    dm_req = 1; dm_we = 0; dm_addr = 32'h400;
    step();
    dm_req = 0;
    step();
    mem_ack = 1; mem_rdata = 32'h7777_7777;
    do_reset();
    check("rst_err", err, 0);
    step(); step();
    check("rst_no_rvalid", dm_rvalid, 0);
    mem_ack = 0;

    // Random traffic
    ack_pct = 40;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (cyc % 400 == 200) ack_pct = 4;
      if (cyc % 400 == 0)   ack_pct = 40;
      mem_ack   = ($urandom_range(0, 99) < ack_pct);
      mem_rdata = $urandom;
      if (!if_req && $urandom_range(0, 99) < 30) begin
        if_req = 1; if_addr = $urandom;
      end else if (if_req && $urandom_range(0, 99) < 3) begin
        if_req = 0;
      end
      if (!dm_req && $urandom_range(0, 99) < 30) begin
        dm_req = 1; dm_we = $urandom_range(0, 1); dm_addr = $urandom; dm_wdata = $urandom;
      end else if (dm_req && $urandom_range(0, 99) < 3) begin
        dm_req = 0;
      end
      step();
      if (e_if_gnt) if_req = 0;
      if (e_dm_gnt) dm_req = 0;
      if (cyc == 1000) begin
        if_req = 0; dm_req = 0;
        do_reset();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
